// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel receiver for a framed, MSB-first bit stream.
// Completed words land in a one-entry valid/ready output buffer; sticky flags
// report dropped words (overflow) and frames restarted by sof (frame_abort).
// Optional feature macro: SHIFT_DESER_PARITY_EN (adds a trailing even-parity bit).
module shift_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             frame_abort,
  input  logic             clr_flags,
  output logic             parity_err
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  // Shift register holds every bit except the one that completes the frame.
  localparam int unsigned SW = FRAME_LEN - 1;
  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             frame_abort_q, frame_abort_d;
  logic             complete;
  logic             word_ok;
  logic [WIDTH-1:0] word;
`ifdef SHIFT_DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  // Next-state logic: frame collection, buffer handshake and flag updates.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shift_d       = shift_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q & ~out_ready;
    overflow_d    = overflow_q & ~clr_flags;
    frame_abort_d = frame_abort_q & ~clr_flags;
    complete      = 1'b0;
    word_ok       = 1'b0;
    word          = '0;
`ifdef SHIFT_DESER_PARITY_EN
    parity_err_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (sin_valid && sof) begin
          shift_d = SW'(sin);
          count_d = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (sin_valid) begin
          if (sof) begin
            frame_abort_d = 1'b1;
            shift_d       = SW'(sin);
            count_d       = CW'(1);
          end else if (count_q == LAST) begin
            complete = 1'b1;
            count_d  = '0;
            state_d  = IDLE;
`ifdef SHIFT_DESER_PARITY_EN
            word         = shift_q;
            word_ok      = (sin == ^shift_q);
            parity_err_d = (sin != ^shift_q);
`else
            word    = {shift_q, sin};
            word_ok = 1'b1;
`endif
          end else begin
            // Explicit cast drops the bit shifted out of the top.
            shift_d = SW'({shift_q, sin});
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A word can enter the buffer when it is empty or being drained this cycle;
    // set events are applied after the clear so they win.
    if (complete && word_ok) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      shift_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_abort_q <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shift_q       <= shift_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      overflow_q    <= overflow_d;
      frame_abort_q <= frame_abort_d;
`ifdef SHIFT_DESER_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign overflow    = overflow_q;
  assign frame_abort = frame_abort_q;
  assign busy        = (state_q == COLLECT);
`ifdef SHIFT_DESER_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench for shift_deser: expected words are queued as frames are
// sent; a negedge monitor pops and compares on every valid/ready transfer.
module tb_shift_deser;
  localparam int W = 8;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sin, sin_valid, sof;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready;
  logic         busy, overflow, frame_abort, clr_flags, parity_err;

  int unsigned  n_pass = 0;
  int unsigned  n_total = 0;
  logic [W-1:0] exp_q[$];

  shift_deser #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow), .frame_abort(frame_abort),
    .clr_flags(clr_flags), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got word %0h expected none at %0t", out_data, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data === e) n_pass++;
        else $display("FAIL sb_word: got %0h expected %0h at %0t", out_data, e, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    sin = b; sof = s; sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0; sof = 1'b0; sin = 1'b0;
  endtask

  // Sends one frame MSB first (plus even parity when enabled).
  task automatic send_frame(input logic [W-1:0] w, input bit gap, input bit rdy_last, input bit clr_last);
    logic [W:0] fr;
`ifdef SHIFT_DESER_PARITY_EN
    fr = {w, ^w};
`else
    fr = {1'b0, w};
`endif
    for (int i = FL - 1; i >= 0; i--) begin
      if (i == 0 && rdy_last) out_ready = 1'b1;
      if (i == 0 && clr_last) clr_flags = 1'b1;
      send_bit(fr[i], i == FL - 1);
      if (i == 0 && clr_last) clr_flags = 1'b0;
      if (gap && i != 0) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v;
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
    out_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_perr", parity_err, 0);

    // Basic receive of 0xA5 with busy tracked during bits 2..8
    out_ready = 1'b1;
    v = 8'hA5;
    exp_q.push_back(v);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(v[i], i == W - 1);
      if (i != 0) begin
        check("basic_busy", busy, 1);
        check("basic_novalid", out_valid, 0);
      end
    end
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(^v, 1'b0);
`endif
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 8'hA5);
    check("basic_busy_end", busy, 0);
    tick();
    check("basic_drained", out_valid, 0);

    // Idle bits without sof are ignored, then 0x3C with gaps
    repeat (3) send_bit(1'b1, 1'b0);
    check("idle_busy", busy, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("gap_valid", out_valid, 1);
    check("gap_data", out_data, 8'h3C);
    tick();

    // Backpressure and overflow; clr on the completing edge must lose to set
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    check("bp_valid", out_valid, 1);
    check("bp_ovf_clear", overflow, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("bp_data_kept", out_data, 8'h11);
    check("bp_ovf_set", overflow, 1);
    out_ready = 1'b1;
    tick();
    check("bp_drained", out_valid, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("bp_ovf_cleared", overflow, 0);

    // Accept and completion in the same cycle
    out_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("sim_valid_old", out_valid, 1);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b0, 1'b1, 1'b0);
    check("sim_valid_new", out_valid, 1);
    check("sim_data_new", out_data, 8'h66);
    check("sim_no_ovf", overflow, 0);
    tick();

    // Abort mid-frame, then full 0xF0 frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("abort_clear_before", frame_abort, 0);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("abort_set", frame_abort, 1);
    check("abort_data", out_data, 8'hF0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("abort_cleared", frame_abort, 0);

    // Reset after 5 bits: partial word lost
    send_bit(1'b1, 1'b1);
    repeat (4) send_bit(1'b0, 1'b0);
    check("rstmid_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", out_valid, 0);
    repeat (4) send_bit(1'b1, 1'b0);
    repeat (8) tick();
    check("rstmid_noword", out_valid, 0);

    // Back-to-back frames
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    check("b2b_data1", out_data, 8'h81);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    check("b2b_data2", out_data, 8'h7E);
    check("b2b_valid2", out_valid, 1);
    tick();

`ifdef SHIFT_DESER_PARITY_EN
    // Good parity loads the word; bad parity pulses parity_err only
    exp_q.push_back(8'hA5);
    v = 8'hA5;
    for (int i = W - 1; i >= 0; i--) send_bit(v[i], i == W - 1);
    send_bit(1'b0, 1'b0);
    check("par_ok_valid", out_valid, 1);
    check("par_ok_perr", parity_err, 0);
    tick();
    for (int i = W - 1; i >= 0; i--) send_bit(v[i], i == W - 1);
    send_bit(1'b1, 1'b0);
    check("par_bad_perr", parity_err, 1);
    check("par_bad_valid", out_valid, 0);
    tick();
    check("par_bad_pulse", parity_err, 0);
`else
    check("perr_tied", parity_err, 0);
`endif

    repeat (4) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-to-parallel receiver at the far end of a serial shift chain.
- Collects a framed, MSB-first bit stream into WIDTH-bit words.
- Presents each word on a one-entry output buffer with a valid/ready handshake.
- Flags overflow and aborted frames; sits between a serial link (my_dff chain) and word-wide consumer logic.

Parameters:
- WIDTH, 8, data bits per frame (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sof  input  1  start of frame; qualified by sin_valid; marks the MSB.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  frame collection in progress.
- overflow  output  1  sticky: a completed word was dropped because the buffer was full.
- frame_abort  output  1  sticky: a frame was restarted by sof before completion.
- clr_flags  input  1  clears overflow and frame_abort next edge.
- parity_err  output  1  one-cycle pulse on parity failure (see Optional Feature).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, busy=0, overflow=0, frame_abort=0, parity_err=0, bit count=0, state=IDLE.
- States: IDLE, COLLECT. Output buffer is a separate register with its own valid bit.
- IDLE:
  - sin_valid&&sof: shift register takes sin as MSB; count=1; go to COLLECT.
  - sin_valid&&!sof: bit ignored.
  - No sin_valid: stay in IDLE.
- COLLECT:
  - Each sin_valid&&!sof cycle: shift left and insert sin at the LSB; count+1.
  - Cycles without sin_valid hold all state.
  - The bit that makes count==FRAME_LEN (WIDTH, or WIDTH+1 with parity) completes the frame and returns the FSM to IDLE.
- Sof mid-frame (COLLECT, sin_valid&&sof):
  - Discard partial word; set frame_abort.
  - Restart with this bit as MSB; count=1; stay in COLLECT.
- busy = (state==COLLECT).
- Completion latency: out_valid and out_data update on the edge after the completing bit, i.e. out_valid is visible the cycle after the last bit is sampled.
- Handshake:
  - Transfer occurs when out_valid&&out_ready.
  - out_data is stable while out_valid=1 and no transfer has occurred.
  - out_ready while out_valid=0 has no effect.
- Completion while buffer empty, or buffer full with out_ready=1 in the same cycle: load new word; out_valid stays or becomes 1; no bubble.
- Completion while out_valid=1 and out_ready=0: drop the new word, keep the old word, set overflow.
- Flag priority: clr_flags and a new set event in the same cycle leaves the flag set.
- Reset mid-frame or with a full buffer: all state returns to reset values; the partial word is lost.
- Back-to-back frames: a sof on the cycle immediately after the completing bit is accepted.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - FRAME_LEN=WIDTH+1; the final bit is an even-parity bit over the WIDTH data bits.
  - On mismatch: the word is not loaded; parity_err pulses for one cycle on the edge after the parity bit; buffer and overflow are unaffected.
  - On match: the word is loaded as in normal completion.
- Undefined:
  - FRAME_LEN=WIDTH; no parity bit.
  - parity_err is tied to 0; the port is still present.

Test Plan:
- Basic receive: reset, then WIDTH=8, bits 1,0,1,0,0,1,0,1 on consecutive cycles with sof on the first bit and out_ready=1 -> out_valid=1 with out_data=0xA5 exactly one cycle after bit 8; busy=1 during bits 2..8.
- Gaps and idle bits: three sin_valid bits without sof, then frame 0x3C with sin_valid deasserted every other cycle -> idle bits ignored; out_data=0x3C; count unaffected by gaps.
- Backpressure and overflow: out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, overflow=1. Then assert out_ready -> out_valid=0 next cycle. Then pulse clr_flags -> overflow=0.
- Simultaneous accept and completion: 0x55 held in buffer, out_ready=1 on the same cycle 0x66 completes -> out_data=0x66 next cycle; out_valid continuously 1; overflow=0.
- Abort and reset: sof after 4 bits of a frame, then a full 0xF0 frame -> frame_abort=1, out_data=0xF0. Separately, reset after 5 bits -> busy=0, out_valid=0, and no word appears afterwards.
- With SHIFT_DESER_PARITY_EN: 0xA5 with parity bit 0 -> word loaded. 0xA5 with parity bit 1 -> parity_err pulses one cycle; out_valid remains 0.
